// File: rtl/idct_pixel_accumulator.sv
// rtl/idct_pixel_accumulator.sv - single-pixel 8x8 IDCT reconstruction from a raster coefficient stream
// Optional clip indicator port and logic enabled by defining IDCT_CLIP_FLAG_EN.
module idct_pixel_accumulator #(
  parameter int COEF_W = 12,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               pixel_row,
  input  logic [2:0]               pixel_column,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_pixel
`ifdef IDCT_CLIP_FLAG_EN
  ,
  output logic                     clip_flag
`endif
);

  localparam int TERM_W = COEF_W + 15;
  localparam int PROD_W = ACC_W + 16;
  localparam logic signed [PROD_W-1:0] SCALE_C  = PROD_W'(26844);
  localparam logic signed [PROD_W-1:0] ROUND_C  = PROD_W'(536870912);
  localparam logic signed [PROD_W-1:0] PIX_BIAS = PROD_W'(128);
  localparam logic signed [PROD_W-1:0] PIX_MAX  = PROD_W'(255);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  state_t     state_q;
  logic [5:0] k_q;
  logic [2:0] x_q;
  logic [2:0] y_q;
  logic       out_valid_q;
  logic [7:0] out_pixel_q;

  // Stage registers: S1 radians, S2 folded index, S3 weights, S4 term, S5 accumulate
  logic                     s1_valid_q, s1_first_q, s1_uz_q, s1_vz_q;
  logic signed [COEF_W-1:0] s1_coef_q;
  logic [4:0]               s1_rad_u_q, s1_rad_v_q;

  logic                     s2_valid_q, s2_first_q, s2_uz_q, s2_vz_q;
  logic signed [COEF_W-1:0] s2_coef_q;
  logic [3:0]               s2_idx_u_q, s2_idx_v_q;
  logic                     s2_neg_u_q, s2_neg_v_q;

  logic                     s3_valid_q, s3_first_q;
  logic signed [COEF_W-1:0] s3_coef_q;
  logic signed [7:0]        s3_wu_q, s3_wv_q;

  logic                     s4_valid_q, s4_first_q;
  logic signed [TERM_W-1:0] s4_term_q;

  logic                     s5_valid_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic                     beat_fire;
  logic                     pipe_busy;
  logic [2:0]               x_sel, y_sel;
  logic [4:0]               rad_u_d, rad_v_d;
  logic [4:0]               fold_u_d, fold_v_d;
  logic signed [7:0]        wu_d, wv_d;
  logic signed [TERM_W-1:0] term_d;
  logic signed [PROD_W-1:0] acc_ext, scaled, pix_full;
  logic [7:0]               pix_d;
  logic                     clip_d;

  // Returns {negative, idx}; maps a 0..31 radian index onto the 0..8 quarter wave
  function automatic logic [4:0] fold(input logic [4:0] r);
    if (r <= 5'd8)       fold = {1'b0, r[3:0]};
    else if (r <= 5'd16) fold = {1'b1, 4'(5'd16 - r)};
    else if (r <= 5'd24) fold = {1'b1, 4'(r - 5'd16)};
    else                 fold = {1'b0, 4'(5'd0 - r)};
  endfunction

  function automatic logic signed [7:0] cos_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    cos_lut = 8'sd100;
      4'd1:    cos_lut = 8'sd98;
      4'd2:    cos_lut = 8'sd92;
      4'd3:    cos_lut = 8'sd83;
      4'd4:    cos_lut = 8'sd71;
      4'd5:    cos_lut = 8'sd56;
      4'd6:    cos_lut = 8'sd38;
      4'd7:    cos_lut = 8'sd20;
      default: cos_lut = 8'sd0;
    endcase
  endfunction

  function automatic logic signed [7:0] weight(input logic zero_freq, input logic neg,
                                               input logic [3:0] idx);
    if (zero_freq) weight = 8'sd71;
    else if (neg)  weight = -cos_lut(idx);
    else           weight = cos_lut(idx);
  endfunction

  assign in_ready  = rst_n && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
  assign beat_fire = in_valid && in_ready;
  assign pipe_busy = s1_valid_q || s2_valid_q || s3_valid_q || s4_valid_q || s5_valid_q;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;

  // Coefficient 0 carries the pixel coordinates, so it must use them before they are latched
  always_comb begin
    x_sel    = (state_q == ST_IDLE) ? pixel_column : x_q;
    y_sel    = (state_q == ST_IDLE) ? pixel_row    : y_q;
    rad_u_d  = 5'({x_sel, 1'b1}) * 5'(k_q[2:0]);
    rad_v_d  = 5'({y_sel, 1'b1}) * 5'(k_q[5:3]);
    fold_u_d = fold(s1_rad_u_q);
    fold_v_d = fold(s1_rad_v_q);
    wu_d     = weight(s2_uz_q, s2_neg_u_q, s2_idx_u_q);
    wv_d     = weight(s2_vz_q, s2_neg_v_q, s2_idx_v_q);
    term_d   = TERM_W'(s3_coef_q) * TERM_W'(s3_wu_q) * TERM_W'(s3_wv_q);
  end

  always_comb begin
    acc_ext  = PROD_W'(acc_q);
    scaled   = (acc_ext * SCALE_C + ROUND_C) >>> 30;
    pix_full = scaled + PIX_BIAS;
    clip_d   = 1'b0;
    pix_d    = pix_full[7:0];
    if (pix_full < 0) begin
      clip_d = 1'b1;
      pix_d  = 8'd0;
    end else if (pix_full > PIX_MAX) begin
      clip_d = 1'b1;
      pix_d  = 8'd255;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;  s1_first_q <= 1'b0;  s1_uz_q <= 1'b0;  s1_vz_q <= 1'b0;
      s1_coef_q  <= '0;    s1_rad_u_q <= '0;    s1_rad_v_q <= '0;
      s2_valid_q <= 1'b0;  s2_first_q <= 1'b0;  s2_uz_q <= 1'b0;  s2_vz_q <= 1'b0;
      s2_coef_q  <= '0;    s2_idx_u_q <= '0;    s2_idx_v_q <= '0;
      s2_neg_u_q <= 1'b0;  s2_neg_v_q <= 1'b0;
      s3_valid_q <= 1'b0;  s3_first_q <= 1'b0;
      s3_coef_q  <= '0;    s3_wu_q    <= '0;    s3_wv_q    <= '0;
      s4_valid_q <= 1'b0;  s4_first_q <= 1'b0;  s4_term_q  <= '0;
      s5_valid_q <= 1'b0;  acc_q      <= '0;
    end else begin
      s1_valid_q <= beat_fire;
      s1_first_q <= (state_q == ST_IDLE);
      s1_uz_q    <= (k_q[2:0] == 3'd0);
      s1_vz_q    <= (k_q[5:3] == 3'd0);
      s1_coef_q  <= in_coef;
      s1_rad_u_q <= rad_u_d;
      s1_rad_v_q <= rad_v_d;

      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_uz_q    <= s1_uz_q;
      s2_vz_q    <= s1_vz_q;
      s2_coef_q  <= s1_coef_q;
      s2_neg_u_q <= fold_u_d[4];
      s2_idx_u_q <= fold_u_d[3:0];
      s2_neg_v_q <= fold_v_d[4];
      s2_idx_v_q <= fold_v_d[3:0];

      s3_valid_q <= s2_valid_q;
      s3_first_q <= s2_first_q;
      s3_coef_q  <= s2_coef_q;
      s3_wu_q    <= wu_d;
      s3_wv_q    <= wv_d;

      s4_valid_q <= s3_valid_q;
      s4_first_q <= s3_first_q;
      s4_term_q  <= term_d;

      s5_valid_q <= s4_valid_q;
      if (s4_valid_q) begin
        if (s4_first_q) acc_q <= ACC_W'(s4_term_q);
        else            acc_q <= acc_q + ACC_W'(s4_term_q);
      end
    end
  end

`ifdef IDCT_CLIP_FLAG_EN
  logic clip_q;
  assign clip_flag = clip_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
`ifdef IDCT_CLIP_FLAG_EN
      clip_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat_fire) begin
            x_q     <= pixel_column;
            y_q     <= pixel_row;
            k_q     <= 6'd1;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat_fire) begin
            if (k_q == 6'd63) state_q <= ST_DRAIN;
            else              k_q     <= k_q + 6'd1;
          end
        end
        ST_DRAIN: begin
          if (!pipe_busy) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= pix_d;
`ifdef IDCT_CLIP_FLAG_EN
            clip_q      <= clip_d;
`endif
            state_q     <= ST_OUTPUT;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            k_q         <= '0;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifndef IDCT_CLIP_FLAG_EN
  logic unused_clip;
  assign unused_clip = clip_d;
`endif

endmodule

// File: doc/idct_pixel_accumulator.md
Name: idct_pixel_accumulator

Overview:
- Decoder-side counterpart of the forward-DCT term pipeline.
- Accepts one 8x8 block of dequantized DCT coefficients, streamed in raster order, and reconstructs a single output pixel (x,y) by accumulating all 64 basis terms.
- Applies the 1/4 scale, the +128 level shift and 0..255 clamping, then presents the pixel on a valid/ready output.
- Uses the same x100 fixed-point cosine table and quarter-wave folding as the encoder, so the two paths are numerically matched.

Parameters:
COEF_W, 12, signed coefficient width (two's complement)
ACC_W, 32, signed accumulator width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
pixel_row  input  3  output pixel y; sampled with coefficient index 0
pixel_column  input  3  output pixel x; sampled with coefficient index 0
in_valid  input  1  coefficient valid
in_ready  output  1  coefficient accept
in_coef  input  COEF_W  signed F(u,v)
out_valid  output  1  pixel valid
out_ready  input  1  pixel accept
out_pixel  output  8  reconstructed unsigned pixel
clip_flag  output  1  present only with IDCT_CLIP_FLAG_EN

Behaviour:
- Reset (async, rst_n=0): state IDLE, coefficient counter 0, accumulator 0, all stage valids 0. Outputs: in_ready=0 while rst_n=0, out_valid=0, out_pixel=0, clip_flag=0.
- Beat acceptance: a beat transfers when in_valid && in_ready. Counter k (6 bits) counts accepted beats.
  - Frequency mapping: v = k[5:3] (row frequency), u = k[2:0] (column frequency).
- Term pipeline, one stage per cycle, with a valid bit per stage and no internal stalls:
  - S1: rad_u = ((2x+1)*u) mod 32 and rad_v = ((2y+1)*v) mod 32, each 7-bit product truncated to 5 bits.
  - S2: fold each radian index r:
    - r<=8: idx=r, positive
    - 8<r<=16: idx=16-r, negative
    - 16<r<=24: idx=r-16, negative
    - r>24: idx=32-r, positive
  - S3: LUT for idx 0..8 = 100,98,92,83,71,56,38,20,0, then apply sign. Weight = 71 when frequency is 0 (C(0) folded in). Result: w_u, w_v in [-100,100], 8-bit signed.
  - S4: term = in_coef * w_u * w_v, 27-bit signed.
  - S5: acc += sign-extended term. The accumulator is cleared on the cycle coefficient 0 enters S5.
- FSM:
  - IDLE: in_ready=1. First accepted beat latches x,y, goes to ACCUM.
  - ACCUM: in_ready=1. The accepted beat with k=63 goes to DRAIN. in_valid low inserts bubbles; the counter holds.
  - DRAIN: in_ready=0. Waits until all stage valids are 0 (exactly 5 cycles after the k=63 beat is accepted), then computes the output and goes to OUTPUT.
  - OUTPUT: in_ready=0. out_valid=1. out_pixel is stable until out_ready=1; on acceptance, go to IDLE and clear k.
- Output arithmetic: s = (acc * 26844 + 2^29) >>> 30 (48-bit signed intermediate, floor shift), p = s + 128, clamp to [0,255].
- Latency: out_valid rises 6 cycles after the k=63 beat is accepted.
- Throughput: 1 beat/cycle while in_valid is held.
- Boundaries:
  - in_valid is ignored outside IDLE/ACCUM.
  - out_ready while out_valid=0 has no effect.
  - Counter wraps 63->0 only through OUTPUT.
  - A reset mid-block discards all partial state; the next beat after reset is treated as k=0.

Optional Feature:
- Macro: IDCT_CLIP_FLAG_EN.
- When defined:
  - clip_flag port exists and is valid with out_valid.
  - clip_flag=1 iff p<0 or p>255 before clamping.
  - It resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset mid-ACCUM after 20 beats, then a full 64-beat block of zeros -> out_pixel=128, out_valid 6 cycles after the last beat.
2. x=3,y=5, F(0,0)=80, all others 0 -> acc=403280, out_pixel=138.
3. x=0,y=0, k=1 coefficient=100, rest 0 -> 145. Same block with x=7 -> 111 (sign fold at r=15).
4. F(0,0)=2047 -> out_pixel=255. F(0,0)=-2048 -> out_pixel=0. With IDCT_CLIP_FLAG_EN, clip_flag=1 in both cases and 0 in scenario 2.
5. Random in_valid gaps (50%), with out_ready held low 10 cycles -> out_pixel stable and in_ready=0 throughout OUTPUT. Result equals the gap-free result.
6. Two back-to-back blocks with different x,y, out_ready=1 -> second block accepted starting the cycle after output handshake; both results match the reference model.
